// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU execute stage.
// Holds the width constants, the opcode and FSM state encodings, and the
// combinational evaluator for the single-cycle operations.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int OP_W  = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_SLT   = 3'b101,
        OP_MUL   = 3'b110,
        OP_PASSB = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_ITER,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
    } alu_out_t;

    // Single-cycle ops. MUL never reaches this path; it returns zeros there.
    function automatic alu_out_t alu_single(opcode_t op, logic [WIDTH-1:0] a,
                                            logic [WIDTH-1:0] b);
        alu_out_t   o;
        logic [WIDTH:0] s;
        o = '0;
        s = '0;
        case (op)
            OP_ADD: begin
                s        = {1'b0, a} + {1'b0, b};
                o.result = s[WIDTH-1:0];
                o.carry  = s[WIDTH];
                o.ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // bit WIDTH of the extended difference is the borrow (a < b unsigned)
                s        = {1'b0, a} - {1'b0, b};
                o.result = s[WIDTH-1:0];
                o.carry  = s[WIDTH];
                o.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   o.result = a & b;
            OP_OR:    o.result = a | b;
            OP_XOR:   o.result = a ^ b;
            OP_SLT:   o.result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_PASSB: o.result = b;
            default:  o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/alu_multicycle_stage_if.sv
// Control-unit <-> execute-stage bundle.
//   master (control unit): drives start/opcode/operand_a/operand_b,
//                          observes busy/done/result/flags.
//   slave  (ALU stage):    the reverse.
interface alu_multicycle_stage_if;
    import alu_pkg::*;

    logic             start;
    logic [OP_W-1:0]  opcode;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_ovf;

    modport master (
        output start, opcode, operand_a, operand_b,
        input  busy, done, result, flag_zero, flag_carry, flag_ovf
    );

    modport slave (
        input  start, opcode, operand_a, operand_b,
        output busy, done, result, flag_zero, flag_carry, flag_ovf
    );

endinterface

// File: rtl/mul_shift_add_unit.sv
// Iterative shift-add multiplier, one multiplier bit per step.
//   clk, rst : clock, synchronous active-high reset
//   load     : latch a (multiplicand) and b (multiplier), clear acc/counter
//   step     : perform one shift-add iteration
//   last     : current step is the final (WIDTH-th) one
//   product  : accumulator value after the current step is applied
module mul_shift_add_unit
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    // Exposing the post-step value lets the owner capture the full product
    // on the same edge as the final iteration.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign last    = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_multicycle_stage.sv
// Execute stage: single-cycle ALU ops plus a WIDTH-step shift-add MUL.
//   wire_clock : clock, rising edge
//   wire_reset : synchronous active-high reset
//   bus        : slave side of the start/busy/done handshake, operands,
//                registered result and flags (held until next completion)
module alu_multicycle_stage
    import alu_pkg::*;
(
    input  logic                     wire_clock,
    input  logic                     wire_reset,
    alu_multicycle_stage_if.slave    bus
);

    state_t             state, state_nxt;
    opcode_t            op;
    logic               accept, is_mul, mul_last, mul_fin;
    logic [2*WIDTH-1:0] mul_product;
    alu_out_t           single;

    logic [WIDTH-1:0]   result_q;
    logic               zero_q, carry_q, ovf_q;

    assign op      = opcode_t'(bus.opcode);
    assign is_mul  = (op == OP_MUL);
    assign accept  = (state == ST_IDLE) && bus.start;
    assign mul_fin = (state == ST_MUL_ITER) && mul_last;
    assign single  = alu_single(op, bus.operand_a, bus.operand_b);

    mul_shift_add_unit u_mul (
        .clk     (wire_clock),
        .rst     (wire_reset),
        .load    (accept && is_mul),
        .step    (state == ST_MUL_ITER),
        .a       (bus.operand_a),
        .b       (bus.operand_b),
        .last    (mul_last),
        .product (mul_product)
    );

    always_ff @(posedge wire_clock) begin
        if (wire_reset) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (bus.start) state_nxt = is_mul ? ST_MUL_ITER : ST_DONE;
            ST_MUL_ITER: if (mul_last)  state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Result/flags update only on the edge that enters DONE.
    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept && !is_mul) begin
            result_q <= single.result;
            zero_q   <= (single.result == '0);
            carry_q  <= single.carry;
            ovf_q    <= single.ovf;
        end else if (mul_fin) begin
            result_q <= mul_product[WIDTH-1:0];
            zero_q   <= (mul_product[WIDTH-1:0] == '0);
            carry_q  <= |mul_product[2*WIDTH-1:WIDTH];
            ovf_q    <= 1'b0;
        end
    end

    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);
    assign bus.result     = result_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_multicycle_stage.sv
// Self-checking bench for alu_multicycle_stage: directed cases plus random
// ops, checked against an arithmetic reference model.
module tb_alu_multicycle_stage;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_multicycle_stage_if bus ();

    alu_multicycle_stage dut (
        .wire_clock (clk),
        .wire_reset (rst),
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode's meaning.
    task automatic model(input int op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic c, output logic v,
                         output logic z);
        logic signed [15:0] as_, bs_;
        int     sa, sb, s;
        longint p;
        as_ = a; bs_ = b; sa = as_; sb = bs_;
        c = 0; v = 0; r = 0;
        case (op)
            0: begin p = longint'(a) + longint'(b); r = p[15:0]; c = (p > 65535);
                     s = sa + sb; v = (s > 32767) || (s < -32768); end
            1: begin r = a - b; c = (a < b);
                     s = sa - sb; v = (s > 32767) || (s < -32768); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sa < sb) ? 16'd1 : 16'd0;
            6: begin p = longint'(a) * longint'(b); r = p[15:0]; c = (p > 65535); end
            default: r = b;
        endcase
        z = (r == 0);
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_op(input int op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] er; logic ec, ev, ez;
        int lat, bcnt, g;
        string t;
        g = 0;
        while (bus.busy && g < 50) begin tick(); g++; end
        chk("idle_before_start", {31'd0, bus.busy}, 0);
        model(op, a, b, er, ec, ev, ez);
        bus.start = 1; bus.opcode = op[2:0]; bus.operand_a = a; bus.operand_b = b;
        tick();
        bus.start = 0;
        lat = 1; bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            tick(); lat++; if (bus.busy) bcnt++;
        end
        t = $sformatf("op%0d_%h_%h", op, a, b);
        chk({t, "_latency"}, lat, (op == 6) ? 17 : 1);
        chk({t, "_busy_cycles"}, bcnt, (op == 6) ? 17 : 1);
        chk({t, "_result"}, {16'd0, bus.result}, {16'd0, er});
        chk({t, "_carry"}, {31'd0, bus.flag_carry}, {31'd0, ec});
        chk({t, "_ovf"}, {31'd0, bus.flag_ovf}, {31'd0, ev});
        chk({t, "_zero"}, {31'd0, bus.flag_zero}, {31'd0, ez});
        tick();
        chk({t, "_done_drop"}, {31'd0, bus.done}, 0);
        chk({t, "_busy_drop"}, {31'd0, bus.busy}, 0);
        chk({t, "_hold"}, {16'd0, bus.result}, {16'd0, er});
    endtask

    initial begin
        int dn;
        logic [15:0] er, mr; logic ec, ev, ez;
        bus.start = 0; bus.opcode = 0; bus.operand_a = 0; bus.operand_b = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_result", {16'd0, bus.result}, 0);
        chk("rst_flags", {29'd0, bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 0);

        // Directed corner cases
        do_op(0, 16'h7FFF, 16'h0001);
        chk("add_ovf_const", {16'd0, bus.result}, 32'h8000);
        do_op(1, 16'h0003, 16'h0005);
        chk("sub_borrow_const", {16'd0, bus.result}, 32'hFFFE);
        do_op(1, 16'h8000, 16'h0001);
        do_op(5, 16'h8000, 16'h0001);
        chk("slt_const", {16'd0, bus.result}, 32'h0001);
        do_op(6, 16'h0123, 16'h0010);
        chk("mul_const", {16'd0, bus.result}, 32'h1230);
        do_op(6, 16'h0100, 16'h0100);
        do_op(6, 16'hFFFF, 16'hFFFF);
        do_op(0, 16'hFFFF, 16'h0001);
        do_op(2, 16'hA5A5, 16'h0FF0);
        do_op(3, 16'hA500, 16'h005A);
        do_op(7, 16'h1234, 16'hBEEF);

        // Start pulsed mid-MUL must be ignored
        model(6, 16'd3, 16'd5, mr, ec, ev, ez);
        bus.start = 1; bus.opcode = 3'd6; bus.operand_a = 16'd3; bus.operand_b = 16'd5;
        tick(); bus.start = 0;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) begin
                bus.start = 1; bus.opcode = 3'd0; bus.operand_a = 1; bus.operand_b = 1;
            end
            if (i == 5) bus.start = 0;
            if (bus.done) begin
                dn++;
                chk("ignore_result", {16'd0, bus.result}, {16'd0, mr});
            end
            tick();
        end
        chk("ignore_done_count", dn, 1);

        // Reset at MUL iteration 8
        bus.start = 1; bus.opcode = 3'd6; bus.operand_a = 16'h1234; bus.operand_b = 16'h0057;
        tick(); bus.start = 0;
        for (int i = 0; i < 7; i++) tick();
        chk("pre_rst_busy", {31'd0, bus.busy}, 1);
        rst = 1; tick(); rst = 0;
        chk("midrst_busy", {31'd0, bus.busy}, 0);
        chk("midrst_done", {31'd0, bus.done}, 0);
        chk("midrst_result", {16'd0, bus.result}, 0);
        chk("midrst_flags", {29'd0, bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 0);
        dn = 0;
        for (int i = 0; i < 20; i++) begin if (bus.done) dn++; tick(); end
        chk("midrst_no_done", dn, 0);
        do_op(2, 16'hF0F0, 16'h0FF0);
        chk("and_after_rst", {16'd0, bus.result}, 32'h00F0);

        // Back-to-back with start held high
        bus.start = 1; bus.opcode = 3'd4; bus.operand_a = 16'hFFFF; bus.operand_b = 16'hFFFF;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("b2b_done_c%0d", i), {31'd0, bus.done}, (i % 2 == 1) ? 1 : 0);
            if (bus.done) begin
                chk("b2b_result", {16'd0, bus.result}, 0);
                chk("b2b_zero", {31'd0, bus.flag_zero}, 1);
            end
        end
        bus.start = 0;
        tick(); tick();

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            int op;
            logic [15:0] a, b;
            op = int'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (i % 5 == 0) b = a;   // exercise equal-operand SUB/SLT/XOR corners
            do_op(op, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
